// File: rtl/unidade_pc_pkg.sv
// unidade_pc_pkg: shared definitions for the PC unit.
//   - tipo_e    : instruction class seen by the PC unit (sequential, branch, JAL, JALR)
//   - F3*       : funct3 branch condition codes
//   - estado_e  : PC-unit FSM states
//   - alinhado(): true when a target address is word aligned
package unidade_pc_pkg;

  typedef enum logic [1:0] {
    TipoSeq    = 2'd0,
    TipoBranch = 2'd1,
    TipoJal    = 2'd2,
    TipoJalr   = 2'd3
  } tipo_e;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [1:0] {
    StBusca   = 2'd0,
    StExecuta = 2'd1,
    StErro    = 2'd2
  } estado_e;

  function automatic logic alinhado(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/condicao_salto.sv
// condicao_salto: combinational taken/not-taken decision for the PC unit.
// Ports:
//   funct3             in  branch condition code (only meaningful for branches)
//   tipo               in  instruction class (see tipo_e)
//   flag_igual         in  ULA equal flag
//   flag_menor         in  ULA signed less-than flag
//   flag_maior_igual_u in  ULA unsigned greater-or-equal flag
//   taken              out redirect is taken
module condicao_salto
  import unidade_pc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] tipo,
  input  logic       flag_igual,
  input  logic       flag_menor,
  input  logic       flag_maior_igual_u,
  output logic       taken
);

  logic cond_branch;

  always_comb begin
    cond_branch = 1'b0;
    case (funct3)
      F3Beq:   cond_branch = flag_igual;
      F3Bne:   cond_branch = ~flag_igual;
      F3Blt:   cond_branch = flag_menor;
      F3Bge:   cond_branch = ~flag_menor;
      F3Bltu:  cond_branch = ~flag_maior_igual_u;
      F3Bgeu:  cond_branch = flag_maior_igual_u;
      default: cond_branch = 1'b0;  // 010/011 are not branch conditions
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (tipo_e'(tipo))
      TipoSeq:    taken = 1'b0;
      TipoBranch: taken = cond_branch;
      TipoJal:    taken = 1'b1;
      TipoJalr:   taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/unidade_pc.sv
// unidade_pc: program counter unit with fetch/execute handshake and misalignment trap.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   instr_ack          instruction word at pc delivered this cycle
//   exec_valid         ULA result/flags/decode fields valid for current instruction
//   tipo, funct3, imm  decode fields (imm sign-extended to BITS)
//   ula_dout           ULA sum (rs1+imm for JALR)
//   flag_*             ULA comparison flags
//   pc, pc_mais4       current pc and its +4 link value
//   instr_req          fetch request (high while fetching)
//   salto_tomado       one-cycle pulse after a taken, aligned redirect
//   erro               sticky misaligned-target trap
module unidade_pc
  import unidade_pc_pkg::*;
#(
  parameter int unsigned     BITS     = 64,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_ack,
  input  logic            exec_valid,
  input  logic [1:0]      tipo,
  input  logic [2:0]      funct3,
  input  logic [BITS-1:0] imm,
  input  logic [BITS-1:0] ula_dout,
  input  logic            flag_igual,
  input  logic            flag_menor,
  input  logic            flag_maior_igual_u,
  output logic [BITS-1:0] pc,
  output logic [BITS-1:0] pc_mais4,
  output logic            instr_req,
  output logic            salto_tomado,
  output logic            erro
);

  localparam logic [BITS-1:0] Quatro = BITS'(4);
  localparam logic [BITS-1:0] Um     = BITS'(1);

  estado_e         estado_q;
  logic [BITS-1:0] pc_q;
  logic            erro_q;
  logic            salto_q;

  logic            taken;
  logic [BITS-1:0] alvo;
  logic            desalinhado;

  condicao_salto u_condicao_salto (
    .funct3             (funct3),
    .tipo               (tipo),
    .flag_igual         (flag_igual),
    .flag_menor         (flag_menor),
    .flag_maior_igual_u (flag_maior_igual_u),
    .taken              (taken)
  );

  // JALR clears bit 0 of the ULA sum; bit 1 is kept so a misaligned JALR still traps.
  always_comb begin
    alvo = pc_q + imm;
    if (tipo_e'(tipo) == TipoJalr) begin
      alvo = ula_dout & ~Um;
    end
    // Only a taken redirect can trap; a not-taken misaligned pc+imm is harmless.
    desalinhado = taken & ~alinhado(alvo[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= StBusca;
      pc_q     <= RESET_PC;
      erro_q   <= 1'b0;
      salto_q  <= 1'b0;
    end else begin
      salto_q <= 1'b0;
      unique case (estado_q)
        StBusca: begin
          if (instr_ack) begin
            estado_q <= StExecuta;
          end
        end
        StExecuta: begin
          if (exec_valid) begin
            if (desalinhado) begin
              estado_q <= StErro;
              erro_q   <= 1'b1;
            end else begin
              pc_q     <= taken ? alvo : pc_q + Quatro;
              salto_q  <= taken;
              estado_q <= StBusca;
            end
          end
        end
        StErro: begin
          erro_q <= 1'b1;
        end
        default: begin
          estado_q <= StErro;
          erro_q   <= 1'b1;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign pc_mais4     = pc_q + Quatro;
  assign instr_req    = (estado_q == StBusca);
  assign salto_tomado = salto_q;
  assign erro         = erro_q;

endmodule

// File: tb/tb_unidade_pc.sv
// tb_unidade_pc: directed scenarios plus randomized instruction stream checked against
// an instruction-level reference model of the PC unit.
module tb_unidade_pc;

  localparam int unsigned  BITS   = 64;
  localparam logic [63:0]  RST_PC = 64'h1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_ack = 1'b0;
  logic            exec_valid = 1'b0;
  logic [1:0]      tipo = 2'd0;
  logic [2:0]      funct3 = 3'd0;
  logic [BITS-1:0] imm = '0;
  logic [BITS-1:0] ula_dout = '0;
  logic            flag_igual = 1'b0;
  logic            flag_menor = 1'b0;
  logic            flag_maior_igual_u = 1'b0;
  logic [BITS-1:0] pc;
  logic [BITS-1:0] pc_mais4;
  logic            instr_req;
  logic            salto_tomado;
  logic            erro;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural pc and trap flag only.
  logic [63:0] m_pc   = RST_PC;
  bit          m_erro = 1'b0;

  unidade_pc #(
    .BITS     (BITS),
    .RESET_PC (RST_PC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_ack          (instr_ack),
    .exec_valid         (exec_valid),
    .tipo               (tipo),
    .funct3             (funct3),
    .imm                (imm),
    .ula_dout           (ula_dout),
    .flag_igual         (flag_igual),
    .flag_menor         (flag_menor),
    .flag_maior_igual_u (flag_maior_igual_u),
    .pc                 (pc),
    .pc_mais4           (pc_mais4),
    .instr_req          (instr_req),
    .salto_tomado       (salto_tomado),
    .erro               (erro)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input int t, input int f3, input bit ig, input bit me,
                                   input bit mgeu);
    if (t == 2 || t == 3) return 1'b1;
    if (t == 0) return 1'b0;
    case (f3)
      0: return ig;
      1: return !ig;
      4: return me;
      5: return !me;
      6: return !mgeu;
      7: return mgeu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic randomize_inputs();
    instr_ack          = 1'($urandom);
    exec_valid         = 1'($urandom);
    tipo               = 2'($urandom);
    funct3             = 3'($urandom);
    imm                = {$urandom, $urandom};
    ula_dout           = {$urandom, $urandom};
    flag_igual         = 1'($urandom);
    flag_menor         = 1'($urandom);
    flag_maior_igual_u = 1'($urandom);
  endtask

  task automatic clear_inputs();
    instr_ack  = 1'b0;
    exec_valid = 1'b0;
    tipo       = 2'd0;
    funct3     = 3'd0;
    imm        = '0;
    ula_dout   = '0;
  endtask

  // Reset asserted away from any clock edge; effects must be visible immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_instr_req", 64'(instr_req), 64'd1);
    check_eq("rst_erro", 64'(erro), 64'd0);
    check_eq("rst_salto", 64'(salto_tomado), 64'd0);
    @(negedge clk);
    clear_inputs();
    rst    = 1'b0;
    m_pc   = RST_PC;
    m_erro = 1'b0;
  endtask

  // Fetch phase: 'hold' cycles without ack (exec_valid may toggle, must be ignored).
  task automatic fetch(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      instr_ack  = 1'b0;
      exec_valid = 1'b1;
      tipo       = 2'd2;
      imm        = 64'h40;
      @(posedge clk);
      #1;
      check_eq("busca_pc_hold", pc, m_pc);
      check_eq("busca_req_hold", 64'(instr_req), 64'd1);
      check_eq("busca_salto_hold", 64'(salto_tomado), 64'd0);
    end
    @(negedge clk);
    instr_ack  = 1'b1;
    exec_valid = 1'($urandom);
    @(posedge clk);
    #1;
    check_eq("ack_pc", pc, m_pc);
    check_eq("ack_instr_req", 64'(instr_req), 64'd0);
    check_eq("ack_salto", 64'(salto_tomado), 64'd0);
  endtask

  task automatic exec_instr(input int t, input int f3, input logic [63:0] im,
                            input logic [63:0] ula, input bit ig, input bit me,
                            input bit mgeu, input int idle);
    logic [63:0] target;
    bit          tk;
    bit          exp_salto;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      exec_valid = 1'b0;
      instr_ack  = 1'($urandom);
      @(posedge clk);
      #1;
      check_eq("exec_idle_pc", pc, m_pc);
      check_eq("exec_idle_req", 64'(instr_req), 64'd0);
    end
    @(negedge clk);
    instr_ack          = 1'b0;
    exec_valid         = 1'b1;
    tipo               = 2'(t);
    funct3             = 3'(f3);
    imm                = im;
    ula_dout           = ula;
    flag_igual         = ig;
    flag_menor         = me;
    flag_maior_igual_u = mgeu;
    #1;
    check_eq("pc_mais4", pc_mais4, m_pc + 64'd4);
    tk        = ref_taken(t, f3, ig, me, mgeu);
    target    = (t == 3) ? (ula & ~64'd1) : m_pc + im;
    exp_salto = 1'b0;
    if (tk && target[1:0] != 2'b00) begin
      m_erro = 1'b1;
    end else if (tk) begin
      m_pc      = target;
      exp_salto = 1'b1;
    end else begin
      m_pc = m_pc + 64'd4;
    end
    @(posedge clk);
    #1;
    check_eq("exec_pc", pc, m_pc);
    check_eq("exec_salto", 64'(salto_tomado), 64'(exp_salto));
    check_eq("exec_erro", 64'(erro), 64'(m_erro));
    check_eq("exec_instr_req", 64'(instr_req), 64'(!m_erro));
    @(negedge clk);
    exec_valid = 1'b0;
  endtask

  // Trap state: everything frozen regardless of inputs.
  task automatic err_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      randomize_inputs();
      @(posedge clk);
      #1;
      check_eq("erro_pc", pc, m_pc);
      check_eq("erro_flag", 64'(erro), 64'd1);
      check_eq("erro_req", 64'(instr_req), 64'd0);
      check_eq("erro_salto", 64'(salto_tomado), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [63:0] rimm;
    logic [63:0] rula;

    do_reset();
    // Sequential instruction from reset pc.
    fetch(0);
    exec_instr(0, 0, 64'h0, 64'h0, 0, 0, 0, 0);

    // BEQ taken / not taken.
    do_reset();
    fetch(0);
    exec_instr(1, 0, 64'h40, 64'h0, 1, 0, 0, 1);
    fetch(1);
    do_reset();
    fetch(0);
    exec_instr(1, 0, 64'h40, 64'h0, 0, 0, 0, 0);

    // BLTU / BGEU at 0x2000 with negative offset.
    do_reset();
    fetch(0);
    exec_instr(3, 0, 64'h0, 64'h2000, 0, 0, 0, 0);
    fetch(0);
    exec_instr(1, 6, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 0, 0, 0);
    fetch(0);
    exec_instr(2, 0, 64'h8, 64'h0, 0, 0, 0, 0);
    fetch(0);
    exec_instr(1, 7, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 0, 0, 2);

    // JALR clears bit 0; JAL to misaligned target traps.
    fetch(0);
    exec_instr(3, 0, 64'h0, 64'h3001, 0, 0, 0, 0);
    fetch(0);
    exec_instr(2, 0, 64'h2, 64'h0, 0, 0, 0, 0);
    err_hold(5);

    // Wrap-around, exec_valid during fetch, misaligned not-taken, never-taken funct3.
    do_reset();
    fetch(0);
    exec_instr(3, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
    fetch(3);
    exec_instr(0, 0, 64'h0, 64'h0, 0, 0, 0, 0);
    fetch(0);
    exec_instr(1, 0, 64'h2, 64'h0, 0, 0, 0, 0);
    fetch(0);
    exec_instr(1, 2, 64'h10, 64'h0, 1, 1, 1, 0);
    fetch(0);
    exec_instr(1, 3, 64'h10, 64'h0, 0, 0, 0, 0);

    // Reset in the middle of EXECUTA with a pending taken JAL.
    fetch(0);
    @(negedge clk);
    exec_valid = 1'b1;
    tipo       = 2'd2;
    imm        = 64'h100;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_exec_pc", pc, RST_PC);
    check_eq("rst_exec_req", 64'(instr_req), 64'd1);
    @(posedge clk);
    #1;
    check_eq("rst_exec_pc_hold", pc, RST_PC);
    check_eq("rst_exec_salto", 64'(salto_tomado), 64'd0);
    @(negedge clk);
    clear_inputs();
    rst    = 1'b0;
    m_pc   = RST_PC;
    m_erro = 1'b0;
    fetch(0);
    exec_instr(0, 0, 64'h0, 64'h0, 0, 0, 0, 0);

    // Randomized instruction stream.
    for (int k = 0; k < 300; k++) begin
      if (m_erro) begin
        err_hold(2);
        do_reset();
      end
      fetch(int'($urandom_range(0, 2)));
      r    = $urandom;
      rimm = {{48{r[15]}}, r[15:0]};
      if ($urandom_range(0, 7) != 0) rimm[1:0] = 2'b00;
      rula = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) rula[1] = 1'b0;
      exec_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), rimm, rula,
                 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
